// File: rtl/xor_scr_pkg.sv
// Shared definitions for the XOR stream scrambler and descrambler.
// Both ends use these so that their key and sequence arithmetic match.
package xor_scr_pkg;
    localparam int DEFAULT_WIDTH = 8;
    localparam int SEQ_RESET     = 0;

    typedef logic [DEFAULT_WIDTH-1:0] data_t;
    typedef logic [DEFAULT_WIDTH-1:0] key_t;
endpackage

// File: rtl/xor_stream_descrambler_if.sv
// Byte stream link with a valid/ready handshake and a start-of-frame marker.
// A beat transfers on a rising edge where valid && ready; the source holds valid/data/sof stable until then.
interface xor_stream_descrambler_if #(
    parameter int WIDTH = xor_scr_pkg::DEFAULT_WIDTH
);
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;
    logic             sof;

    modport master (output valid, data, sof, input ready);
    modport slave  (input valid, data, sof, output ready);
endinterface

// File: rtl/xor_pipe_stage.sv
// One valid/ready register slice that XORs a term into the data as it loads.
// The slice can be refilled in the same cycle that it drains, so it sustains one beat per cycle.
module xor_pipe_stage import xor_scr_pkg::*; #(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sof,
    input  logic [WIDTH-1:0] term,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_sof
);
    logic load;

    assign in_ready = !out_valid || out_ready;
    assign load     = in_valid && in_ready;

    // When no beat is loaded, data holds its last value and only valid drops.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sof   <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= in_data ^ term;
            out_sof   <= in_sof;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: rtl/xor_stream_descrambler.sv
// Receive-side descrambler. It removes the round-0 key and the rolling beat sequence in stage 1,
// and removes the round-1 key in stage 2. It also holds the key registers and the sequence counter.
module xor_stream_descrambler import xor_scr_pkg::*; #(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter bit SEQ_EN = 1'b1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     cfg_load,
    input  logic [WIDTH-1:0]         cfg_key_0,
    input  logic [WIDTH-1:0]         cfg_key_1,
    output logic                     cfg_err,
    xor_stream_descrambler_if.slave  up,
    xor_stream_descrambler_if.master dn,
    output logic                     busy
);
    logic [WIDTH-1:0] key_0;
    logic [WIDTH-1:0] key_1;
    logic [WIDTH-1:0] seq;
    logic [WIDTH-1:0] seq_used;
    logic [WIDTH-1:0] s1_data;
    logic             s1_valid;
    logic             s1_sof;
    logic             s1_ready;
    logic             s2_free;
    logic             accept;

    assign up.ready = reset && s1_ready;
    assign accept   = up.valid && up.ready;
    assign busy     = s1_valid || dn.valid;
    assign seq_used = (SEQ_EN && !up.sof) ? seq : WIDTH'(SEQ_RESET);

    // Keys may only change while the pipeline is empty and no beat is entering,
    // so every beat is decoded with a single, consistent pair of keys.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            key_0   <= '0;
            key_1   <= '0;
            seq     <= WIDTH'(SEQ_RESET);
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= cfg_load && (busy || accept);
            if (cfg_load && !busy && !accept) begin
                key_0 <= cfg_key_0;
                key_1 <= cfg_key_1;
            end
            if (accept) begin
                seq <= seq_used + 1'b1;
            end
        end
    end

    xor_pipe_stage #(.WIDTH(WIDTH)) u_stage1 (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (up.valid),
        .in_ready  (s1_ready),
        .in_data   (up.data),
        .in_sof    (up.sof),
        .term      (key_0 ^ seq_used),
        .out_valid (s1_valid),
        .out_ready (s2_free),
        .out_data  (s1_data),
        .out_sof   (s1_sof)
    );

    xor_pipe_stage #(.WIDTH(WIDTH)) u_stage2 (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (s1_valid),
        .in_ready  (s2_free),
        .in_data   (s1_data),
        .in_sof    (s1_sof),
        .term      (key_1),
        .out_valid (dn.valid),
        .out_ready (dn.ready),
        .out_data  (dn.data),
        .out_sof   (dn.sof)
    );
endmodule

// File: tb/tb_xor_stream_descrambler.sv
// Bench for xor_stream_descrambler. It runs a SEQ_EN=1 and a SEQ_EN=0 instance in lockstep
// on the same stimulus, and checks both against a plaintext model that runs beat by beat.
module tb_xor_stream_descrambler;
  import xor_scr_pkg::*;

  typedef struct {
    string      name;
    logic [7:0] key_0;
    logic [7:0] key_1;
    logic [7:0] data;
    logic       sof;
    logic [7:0] exp_a;
    logic [7:0] exp_b;
  } vec_t;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       cfg_load = 1'b0;
  logic [7:0] cfg_key_0 = '0;
  logic [7:0] cfg_key_1 = '0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_sof = 1'b0;
  logic       out_ready = 1'b1;
  logic       cfg_err_a, cfg_err_b, busy_a, busy_b;

  int n_checks = 0;
  int n_errors = 0;

  // Each entry is {sof, expected plaintext for SEQ_EN=0, expected plaintext for SEQ_EN=1}.
  logic [16:0] exp_q[$];
  int          m_seq = 0;
  logic [7:0]  m_key_0 = '0;
  logic [7:0]  m_key_1 = '0;
  logic        pend_err = 1'b0;
  logic        busy_m, acc_m;
  logic [16:0] ent;
  logic [7:0]  su;

  xor_stream_descrambler_if #(.WIDTH(8)) up_a ();
  xor_stream_descrambler_if #(.WIDTH(8)) dn_a ();
  xor_stream_descrambler_if #(.WIDTH(8)) up_b ();
  xor_stream_descrambler_if #(.WIDTH(8)) dn_b ();

  assign up_a.valid = in_valid;
  assign up_a.data  = in_data;
  assign up_a.sof   = in_sof;
  assign dn_a.ready = out_ready;
  assign up_b.valid = in_valid;
  assign up_b.data  = in_data;
  assign up_b.sof   = in_sof;
  assign dn_b.ready = out_ready;

  xor_stream_descrambler #(.WIDTH(8), .SEQ_EN(1'b1)) dut_a (
    .clock(clock), .reset(reset), .cfg_load(cfg_load),
    .cfg_key_0(cfg_key_0), .cfg_key_1(cfg_key_1), .cfg_err(cfg_err_a),
    .up(up_a), .dn(dn_a), .busy(busy_a)
  );

  xor_stream_descrambler #(.WIDTH(8), .SEQ_EN(1'b0)) dut_b (
    .clock(clock), .reset(reset), .cfg_load(cfg_load),
    .cfg_key_0(cfg_key_0), .cfg_key_1(cfg_key_1), .cfg_err(cfg_err_b),
    .up(up_b), .dn(dn_b), .busy(busy_b)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  task automatic apply_reset();
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // ---------------- scoreboard / reference model ----------------
  always @(negedge clock) begin
    if (!reset) begin
      check("ready_in_reset", up_a.ready, 0);
      check("valid_in_reset", dn_a.valid, 0);
      check("data_in_reset", dn_a.data, 0);
      check("busy_in_reset", busy_a, 0);
      exp_q.delete();
      m_seq    = 0;
      m_key_0  = '0;
      m_key_1  = '0;
      pend_err = 1'b0;
    end else begin
      busy_m = (exp_q.size() != 0);
      acc_m  = in_valid && up_a.ready;
      check("cfg_err_a", cfg_err_a, pend_err);
      check("cfg_err_b", cfg_err_b, pend_err);
      check("busy_a", busy_a, busy_m);
      check("busy_b", busy_b, busy_m);
      check("in_ready_a", up_a.ready, (exp_q.size() < 2) || out_ready);
      check("in_ready_b", up_b.ready, (exp_q.size() < 2) || out_ready);
      if (dn_a.valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", 1, 0);
        end else begin
          ent = exp_q.pop_front();
          check("sb_data_a", dn_a.data, ent[7:0]);
          check("sb_sof_a", dn_a.sof, ent[16]);
          check("sb_valid_b", dn_b.valid, 1);
          check("sb_data_b", dn_b.data, ent[15:8]);
          check("sb_sof_b", dn_b.sof, ent[16]);
        end
      end
      if (acc_m) begin
        su = in_sof ? 8'd0 : 8'(m_seq);
        exp_q.push_back({in_sof, in_data ^ m_key_0 ^ m_key_1,
                         in_data ^ m_key_0 ^ m_key_1 ^ su});
        m_seq = (int'(su) + 1) % 256;
      end
      if (cfg_load && !busy_m && !acc_m) begin
        m_key_0 = cfg_key_0;
        m_key_1 = cfg_key_1;
      end
      pend_err = cfg_load && (busy_m || acc_m);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [7:0] d, input logic s);
    int guard = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_sof   = s;
    @(negedge clock);
    while (!up_a.ready && guard < 200) begin
      guard++;
      @(negedge clock);
    end
    if (guard >= 200) timeout("send");
    @(posedge clock);
    #1 in_valid = 1'b0;
  endtask

  task automatic cfg_pulse(input logic [7:0] k0, input logic [7:0] k1);
    cfg_load  = 1'b1;
    cfg_key_0 = k0;
    cfg_key_1 = k1;
    @(posedge clock);
    #1 cfg_load = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic drain();
    int guard = 0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && guard < 100) begin
      @(posedge clock);
      #1 guard++;
    end
    if (guard >= 100) timeout("drain");
    idle(1);
  endtask

  // ---------------- test sequence ----------------
  vec_t vecs[4];
  int   acc_n, gaps;
  logic took;
  logic [7:0] d255, d256;
  bit   done;

  initial begin
    vecs[0] = '{"vec_basic",  8'h5A, 8'h3C, 8'hA5, 1'b1, 8'hC3, 8'hC3};
    vecs[1] = '{"vec_zero",   8'h5A, 8'h3C, 8'h00, 1'b1, 8'h66, 8'h66};
    vecs[2] = '{"vec_cancel", 8'h11, 8'h22, 8'h33, 1'b1, 8'h00, 8'h00};
    vecs[3] = '{"vec_ones",   8'hFF, 8'h00, 8'hFF, 1'b1, 8'h00, 8'h00};

    apply_reset();
    @(negedge clock);
    check("rst_in_ready", up_a.ready, 1);
    check("rst_busy", busy_a, 0);
    check("rst_cfg_err", cfg_err_a, 0);
    check("rst_out_valid", dn_a.valid, 0);
    check("rst_out_data", dn_a.data, 0);
    @(posedge clock);
    #1;

    // Single-beat vectors with key reload while idle
    foreach (vecs[i]) begin
      cfg_pulse(vecs[i].key_0, vecs[i].key_1);
      send(vecs[i].data, vecs[i].sof);
      drain();
      check({vecs[i].name, "_a"}, dn_a.data, vecs[i].exp_a);
      check({vecs[i].name, "_b"}, dn_b.data, vecs[i].exp_b);
    end

    // Test 1: exact two-cycle latency
    cfg_pulse(8'h5A, 8'h3C);
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 8'hA5; in_sof = 1'b1;
    @(negedge clock);
    check("t1_ready", up_a.ready, 1);
    @(posedge clock);
    #1 in_data = 8'h00; in_sof = 1'b0;
    @(negedge clock);
    check("t1_not_early", dn_a.valid, 0);
    @(posedge clock);
    #1 in_valid = 1'b0;
    @(negedge clock);
    check("t1_valid0", dn_a.valid, 1);
    check("t1_data0", dn_a.data, 8'hC3);
    check("t1_sof0", dn_a.sof, 1);
    check("t1_data0_b", dn_b.data, 8'hC3);
    @(negedge clock);
    check("t1_valid1", dn_a.valid, 1);
    check("t1_data1", dn_a.data, 8'h67);
    check("t1_sof1", dn_a.sof, 0);
    check("t1_data1_b", dn_b.data, 8'h66);
    drain();

    // Test 2: 257 back-to-back beats, sequence wraps, no gaps
    gaps = 0;
    fork
      begin
        send(8'h00, 1'b1);
        for (int i = 1; i < 257; i++) send(8'h00, 1'b0);
      end
      begin
        int g = 0;
        @(negedge clock);
        while (!dn_a.valid && g < 20) begin
          g++;
          @(negedge clock);
        end
        for (int i = 0; i < 257; i++) begin
          if (!dn_a.valid) gaps++;
          if (i == 255) d255 = dn_a.data;
          if (i == 256) d256 = dn_a.data;
          @(negedge clock);
        end
      end
    join
    check("t2_gaps", gaps, 0);
    check("t2_seq255", d255, 8'h99);
    check("t2_wrap", d256, 8'h66);
    drain();

    // Test 3: stalled output, input held valid for 5 cycles
    out_ready = 1'b0;
    in_valid = 1'b1; in_sof = 1'b0; in_data = 8'h10;
    acc_n = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      took = up_a.ready;
      if (took) acc_n++;
      @(posedge clock);
      #1 if (took) in_data = in_data + 8'd1;
    end
    check("t3_accepts", acc_n, 2);
    @(negedge clock);
    check("t3_ready_low", up_a.ready, 0);
    check("t3_busy", busy_a, 1);
    @(posedge clock);
    #1 out_ready = 1'b1;
    send(in_data, 1'b0);
    send(in_data + 8'd1, 1'b0);
    drain();
    check("t3_drained", exp_q.size(), 0);

    // Test 4: key load rejected while busy, accepted when idle
    out_ready = 1'b0;
    send(8'h33, 1'b1);
    cfg_pulse(8'h11, 8'h22);
    @(negedge clock);
    check("t4_err_pulse", cfg_err_a, 1);
    @(negedge clock);
    check("t4_err_clear", cfg_err_a, 0);
    @(posedge clock);
    #1;
    drain();
    check("t4_old_keys", dn_a.data, 8'h55);
    check("t4_hold_valid", dn_a.valid, 0);
    cfg_pulse(8'h11, 8'h22);
    @(negedge clock);
    check("t4_no_err", cfg_err_a, 0);
    @(posedge clock);
    #1;
    send(8'h33, 1'b1);
    drain();
    check("t4_new_keys", dn_a.data, 8'h00);
    cfg_load = 1'b1; cfg_key_0 = 8'h77; cfg_key_1 = 8'h88;
    send(8'h33, 1'b1);
    cfg_load = 1'b0;
    @(negedge clock);
    check("t4_err_on_accept", cfg_err_a, 1);
    @(posedge clock);
    #1;
    drain();
    check("t4_keys_kept", dn_a.data, 8'h00);

    // Test 5: reset mid-frame with two beats in flight
    out_ready = 1'b0;
    send(8'h01, 1'b1);
    send(8'h02, 1'b0);
    check("t5_busy", busy_a, 1);
    reset = 1'b0;
    #1;
    check("t5_valid_async", dn_a.valid, 0);
    check("t5_ready_async", up_a.ready, 0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    check("t5_busy_after", busy_a, 0);
    check("t5_ready_after", up_a.ready, 1);
    @(posedge clock);
    #1 out_ready = 1'b1;
    cfg_pulse(8'h5A, 8'h3C);
    send(8'h00, 1'b0);
    drain();
    check("t5_seq0_a", dn_a.data, 8'h66);
    check("t5_seq0_b", dn_b.data, 8'h66);

    // Randomized traffic with random backpressure and key reloads
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(0, 15) == 0) cfg_pulse(8'($urandom), 8'($urandom));
          send(8'($urandom), $urandom_range(0, 7) == 0);
          if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clock);
          #1 out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    drain();
    check("final_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
